// File: rtl/epcs16_stream_reader.sv
// Sequential byte-stream front end for the EPCS16 read cache: walks an address
// range, captures each byte on a cache hit and streams it out through a FWFT FIFO.
module epcs16_stream_reader #(
   parameter int LENGTH_WIDTH = 16,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                    Clk,
   input  logic                    Reset,
   input  logic                    Start,
   input  logic [20:0]             Start_Address,
   input  logic [LENGTH_WIDTH-1:0] Length,
   input  logic                    Abort,
   output logic                    Busy,
   output logic                    Done,
   output logic [20:0]             Cache_Address,
   input  logic [7:0]              Cache_Data,
   input  logic                    Cache_Data_Valid,
   output logic [7:0]              Stream_Data,
   output logic                    Stream_Valid,
   input  logic                    Stream_Ready
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      FETCH  = 2'd2,
      DRAIN  = 2'd3
   } state_t;

   state_t                  state_r;
   state_t                  state_s;
   logic [20:0]             addr_r;
   logic [20:0]             addr_s;
   logic [LENGTH_WIDTH-1:0] rem_r;
   logic [LENGTH_WIDTH-1:0] rem_s;
   logic                    busy_r;
   logic                    busy_s;
   logic                    done_r;
   logic                    done_s;
   logic                    push_s;
   logic                    pop_s;
   logic                    flush_s;
   logic                    full_s;

   logic [7:0]              fifo_mem_r [FIFO_DEPTH];
   logic [PTR_W-1:0]        wr_ptr_r;
   logic [PTR_W-1:0]        rd_ptr_r;
   logic [CNT_W-1:0]        count_r;
   logic [CNT_W-1:0]        count_s;
   logic                    valid_r;

   assign full_s = (count_r == CNT_FULL);
   assign pop_s  = valid_r & Stream_Ready;

   // Next-state and datapath decisions; Abort overrides everything outside IDLE
   always_comb begin
      state_s = state_r;
      addr_s  = addr_r;
      rem_s   = rem_r;
      busy_s  = busy_r;
      done_s  = 1'b0;
      push_s  = 1'b0;
      flush_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (Start) begin
               if (Length != {LENGTH_WIDTH{1'b0}}) begin
                  addr_s  = Start_Address;
                  rem_s   = Length;
                  busy_s  = 1'b1;
                  state_s = SETTLE;
               end else begin
                  done_s  = 1'b1;
               end
            end else begin
               state_s = IDLE;
            end
         end
         SETTLE: begin
            state_s = FETCH;
         end
         FETCH: begin
            // a full FIFO blocks the push even when a pop frees a slot this cycle
            if (Cache_Data_Valid && !full_s) begin
               push_s  = 1'b1;
               addr_s  = addr_r + 21'd1;
               rem_s   = rem_r - LENGTH_WIDTH'(1);
               state_s = (rem_r > LENGTH_WIDTH'(1)) ? SETTLE : DRAIN;
            end else begin
               state_s = FETCH;
            end
         end
         DRAIN: begin
            if ((count_r == {CNT_W{1'b0}}) || ((count_r == CNT_W'(1)) && pop_s)) begin
               busy_s  = 1'b0;
               done_s  = 1'b1;
               state_s = IDLE;
            end else begin
               state_s = DRAIN;
            end
         end
         default: begin
            busy_s  = 1'b0;
            state_s = IDLE;
         end
      endcase
      if (Abort && (state_r != IDLE)) begin
         state_s = IDLE;
         busy_s  = 1'b0;
         done_s  = 1'b0;
         push_s  = 1'b0;
         flush_s = 1'b1;
      end else begin
         flush_s = 1'b0;
      end
   end

   // FIFO occupancy after this cycle's push/pop
   always_comb begin
      count_s = count_r;
      case ({push_s, pop_s})
         2'b10:   count_s = count_r + CNT_W'(1);
         2'b01:   count_s = count_r - CNT_W'(1);
         default: count_s = count_r;
      endcase
   end

   // FSM state and transfer registers
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_r <= IDLE;
         addr_r  <= 21'd0;
         rem_r   <= {LENGTH_WIDTH{1'b0}};
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         addr_r  <= addr_s;
         rem_r   <= rem_s;
         busy_r  <= busy_s;
         done_r  <= done_s;
      end
   end

   // FIFO pointers, occupancy and registered not-empty flag
   always_ff @(posedge Clk) begin
      if (Reset || flush_s) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
         valid_r  <= 1'b0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         count_r <= count_s;
         valid_r <= (count_s != {CNT_W{1'b0}});
      end
   end

   // FIFO storage; contents are don't-care while the matching slot is empty
   always_ff @(posedge Clk) begin
      if (push_s) begin
         fifo_mem_r[wr_ptr_r] <= Cache_Data;
      end
   end

   assign Busy          = busy_r;
   assign Done          = done_r;
   assign Cache_Address = addr_r;
   assign Stream_Valid  = valid_r;
   assign Stream_Data   = fifo_mem_r[rd_ptr_r];

endmodule
